if_fetch_unit: RTL

//  Instruction-fetch front end. Drives the instruction-memory request handshake,

---
 rtl/if_fetch_unit_if.sv | 33 +++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_if
//  Description : Instruction-memory request/response bus used by the fetch
//                front end.
//                  imem_req   : fetch unit requests a word
//                  imem_addr  : word address, held while req=1 and no ack
//                  imem_ack   : memory returns data (may be same cycle as req)
//                  imem_rdata : instruction word, valid only with imem_ack
//                Modports: master (fetch unit side), slave (memory side).
//  Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch front end. Issues instruction-memory
//                requests, tracks the fetch PC, redirects on taken branches
//                and presents PC+4 / Instruction / Valid to IF/ID.
//                Absorbs variable memory latency, downstream freeze and
//                branch flushes; invalid cycles present a bubble.
//  Ports       : clk          pipeline clock, rising edge
//                rst          asynchronous reset, active low
//                freeze       IF/ID does not capture this cycle
//                branch_taken redirect request from EXE
//                branch_addr  redirect target (bits [1:0] ignored)
//                imem         instruction memory bus (master side)
//                PC           address of presented instruction + 4
//                Instruction  fetched word, 0 when Valid=0
//                Valid        Instruction/PC carry a real fetch
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        freeze,
    input  wire logic        branch_taken,
    input  wire logic [31:0] branch_addr,
    if_fetch_unit_if.master  imem,
    output logic      [31:0] PC,
    output logic      [31:0] Instruction,
    output logic             Valid
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] old_addr_q, old_addr_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic        unused_addr_bits;

    assign pc_plus4         = pc_q + 32'd4;
    assign branch_tgt       = {branch_addr[31:2], 2'b00};
    assign unused_addr_bits = &{1'b0, branch_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            old_addr_q <= 32'h0;
            buf_inst_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_addr_q <= old_addr_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        old_addr_d     = old_addr_q;
        buf_inst_d     = buf_inst_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        Valid          = 1'b0;
        Instruction    = 32'h0;
        PC             = 32'h0;

        case (state_q)
            S_REQ: begin
                imem.imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = branch_tgt;
                    // An outstanding request cannot be aborted: remember
                    // its address and swallow the response in DRAIN.
                    if (!imem.imem_ack) begin
                        old_addr_d = pc_q;
                        state_d    = S_DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    Valid       = 1'b1;
                    Instruction = imem.imem_rdata;
                    PC          = pc_plus4;
                    if (freeze) begin
                        // IF/ID will not capture; keep the word for replay.
                        buf_inst_d = imem.imem_rdata;
                        state_d    = S_HOLD;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_tgt;
                    state_d = S_REQ;
                end else begin
                    Valid       = 1'b1;
                    Instruction = buf_inst_q;
                    PC          = pc_plus4;
                    if (!freeze) begin
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end
                end
            end

            S_DRAIN: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = old_addr_q;
                // A further redirect only retargets the PC; the stale
                // request still has to be drained.
                if (branch_taken) begin
                    pc_d = branch_tgt;
                end else if (imem.imem_ack) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        // Reset forces a quiet bus and a bubble regardless of register state.
        if (!rst) begin
            imem.imem_req = 1'b0;
            Valid         = 1'b0;
            Instruction   = 32'h0;
            PC            = 32'h0;
        end
    end

endmodule
`default_nettype wire
